// File: rtl/pico_pkg.sv
// ============================================================================
// Module  : pico_pkg
// Brief   : Shared opcode, ALU function, FSM state and width definitions.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pico_pkg;

  localparam int INSTR_W = 16;
  localparam int RADDR_W = 3;
  localparam int FUNC_W  = 3;

  // Shared ALU function code set
  typedef enum logic [FUNC_W-1:0] {
    RA   = 3'd0,
    RB   = 3'd1,
    RADD = 3'd2,
    RSUB = 3'd3,
    RAND = 3'd4,
    ROR  = 3'd5,
    RXOR = 3'd6,
    RNOR = 3'd7
  } alu_func_t;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_AND   = 4'h3,
    OP_OR    = 4'h4,
    OP_XOR   = 4'h5,
    OP_NOR   = 4'h6,
    OP_MOV   = 4'h7,
    OP_ADDI  = 4'h8,
    OP_LDI   = 4'h9,
    OP_BEQ   = 4'hA,
    OP_J     = 4'hB,
    OP_ILL_C = 4'hC,
    OP_ILL_D = 4'hD,
    OP_ILL_E = 4'hE,
    OP_HALT  = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    CL_SEQ    = 2'd0,
    CL_BRANCH = 2'd1,
    CL_JUMP   = 2'd2,
    CL_HALT   = 2'd3
  } flow_t;

  typedef logic [2:0] state_t;
  localparam state_t S_FETCH  = 3'd0;
  localparam state_t S_DECODE = 3'd1;
  localparam state_t S_EXEC   = 3'd2;
  localparam state_t S_WB     = 3'd3;
  localparam state_t S_HALT   = 3'd4;

endpackage

`default_nettype wire

// File: rtl/pico_if.sv
// ============================================================================
// Module  : pico_if
// Brief   : Instruction-memory and datapath-control bundle of pico_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pico_if #(
  parameter int N  = 8,
  parameter int PW = 8
);
  logic          instr_req;
  logic [PW-1:0] pc;
  logic [15:0]   instr;
  logic          instr_valid;
  logic          zf;
  logic [2:0]    alu_func;
  logic          b_sel;
  logic [N-1:0]  imm;
  logic [2:0]    rd_addr;
  logic [2:0]    rs_addr;
  logic          reg_we;
  logic          halted;
  logic          illegal;

  modport master (
    output instr_req, pc, alu_func, b_sel, imm, rd_addr, rs_addr,
           reg_we, halted, illegal,
    input  instr, instr_valid, zf
  );

  modport slave (
    input  instr_req, pc, alu_func, b_sel, imm, rd_addr, rs_addr,
           reg_we, halted, illegal,
    output instr, instr_valid, zf
  );
endinterface

`default_nettype wire

// File: rtl/pico_decode.sv
// ============================================================================
// Module  : pico_decode
// Brief   : Combinational opcode decoder: ALU function, B-mux, write, flow.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pico_decode
  import pico_pkg::*;
(
  input  opcode_t    opcode,
  output logic [2:0] alu_func,
  output logic       b_sel,
  output logic       we,
  output flow_t      flow,
  output logic       illegal
);

  always_comb begin
    alu_func = RA;
    b_sel    = 1'b0;
    we       = 1'b0;
    flow     = CL_SEQ;
    illegal  = 1'b0;
    case (opcode)
      OP_ADD:  begin alu_func = RADD; we = 1'b1; end
      OP_SUB:  begin alu_func = RSUB; we = 1'b1; end
      OP_AND:  begin alu_func = RAND; we = 1'b1; end
      OP_OR:   begin alu_func = ROR;  we = 1'b1; end
      OP_XOR:  begin alu_func = RXOR; we = 1'b1; end
      OP_NOR:  begin alu_func = RNOR; we = 1'b1; end
      OP_MOV:  begin alu_func = RB;   we = 1'b1; end
      OP_ADDI: begin alu_func = RADD; we = 1'b1; b_sel = 1'b1; end
      OP_LDI:  begin alu_func = RB;   we = 1'b1; b_sel = 1'b1; end
      OP_BEQ:  begin alu_func = RSUB; flow = CL_BRANCH; end
      OP_J:    flow = CL_JUMP;
      OP_HALT: flow = CL_HALT;
      OP_ILL_C, OP_ILL_D, OP_ILL_E: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pico_ctrl.sv
// ============================================================================
// Module  : pico_ctrl
// Brief   : Multi-cycle FETCH/DECODE/EXEC/WB controller for the pico core.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pico_ctrl
  import pico_pkg::*;
#(
  parameter int N  = 8,
  parameter int PW = 8
) (
  input  logic   clk,
  input  logic   nReset,
  pico_if.master bus
);

  state_t        r_state;
  logic [15:0]   r_ir;
  logic [PW-1:0] r_pc;
  logic          r_taken;

  logic [2:0]    w_func;
  logic          w_bsel;
  logic          w_we;
  flow_t         w_flow;
  logic          w_ill;
  logic          w_active;
  logic [PW-1:0] w_off;
  logic [PW-1:0] w_pc_next;

  pico_decode u_decode (
    .opcode   (opcode_t'(r_ir[15:12])),
    .alu_func (w_func),
    .b_sel    (w_bsel),
    .we       (w_we),
    .flow     (w_flow),
    .illegal  (w_ill)
  );

  assign w_active = (r_state == S_DECODE) || (r_state == S_EXEC) || (r_state == S_WB);
  assign w_off    = PW'($signed(r_ir[5:0]));

  always_comb begin
    w_pc_next = r_pc + PW'(1);
    if (w_flow == CL_JUMP)
      w_pc_next = PW'(r_ir[7:0]);
    else if (w_flow == CL_BRANCH && r_taken)
      w_pc_next = r_pc + PW'(1) + w_off;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_FETCH;
      r_ir    <= '0;
      r_pc    <= '0;
      r_taken <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (bus.instr_valid) begin
            r_ir    <= bus.instr;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: r_state <= S_EXEC;
        S_EXEC: begin
          r_taken <= (w_flow == CL_BRANCH) && bus.zf;
          r_state <= (w_flow == CL_HALT) ? S_HALT : S_WB;
        end
        S_WB: begin
          r_pc    <= w_pc_next;
          r_state <= S_FETCH;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Outputs derive from registered state/IR so reset clears them immediately
  assign bus.instr_req = (r_state == S_FETCH);
  assign bus.pc        = r_pc;
  assign bus.alu_func  = w_active ? w_func : RA;
  assign bus.b_sel     = w_active & w_bsel;
  assign bus.imm       = N'(r_ir[7:0]);
  assign bus.rd_addr   = r_ir[11:9];
  assign bus.rs_addr   = r_ir[8:6];
  assign bus.reg_we    = (r_state == S_WB) & w_we;
  assign bus.halted    = (r_state == S_HALT);
  assign bus.illegal   = (r_state == S_EXEC) & w_ill;

endmodule

`default_nettype wire
